// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Writeback arbiter in front of the register file. Each functional-unit
//   result channel feeds a small per-source FIFO. Every cycle the FIFO heads
//   are scanned round-robin starting at rr_q. Up to NR_WRITE_PORTS heads are
//   granted onto the write ports, and no two granted ports ever carry the same
//   destination register. Heads targeting x0 are dropped without using a port.
//
//   Optional build macro: WB_BYPASS_EN
//     Defined   - an empty FIFO with src_valid_i high offers its input as a
//                 virtual head. If granted, it is written in the same cycle
//                 and never enters the FIFO.
//     Undefined - minimum latency from push to write is one cycle.
//
//   Ports
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     src_valid_i     per-source result valid
//     src_ready_o     per-source FIFO not full (registered count only)
//     src_waddr_i     per-source destination register
//     src_wdata_i     per-source result data
//     waddr_o         per-port register-file write address (0 when idle)
//     wdata_o         per-port register-file write data (0 when idle)
//     we_o            per-port write enable
//     busy_o          some source FIFO holds an entry
//
//   Handshake: a result is accepted on a cycle where src_valid_i and
//   src_ready_o are both high. The source keeps valid and payload stable until
//   then. src_ready_o depends only on registered state, never on src_valid_i.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int NR_SOURCES     = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NR_SOURCES-1:0]                      src_valid_i,
    output logic [NR_SOURCES-1:0]                      src_ready_o,
    input  logic [NR_SOURCES-1:0][4:0]                 src_waddr_i,
    input  logic [NR_SOURCES-1:0][DATA_WIDTH-1:0]      src_wdata_i,
    output logic [NR_WRITE_PORTS-1:0][4:0]             waddr_o,
    output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_o,
    output logic [NR_WRITE_PORTS-1:0]                  we_o,
    output logic                                       busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W  = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1;

    logic [NR_SOURCES-1:0][FIFO_DEPTH-1:0][4:0]            mem_waddr_q, mem_waddr_d;
    logic [NR_SOURCES-1:0][FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [NR_SOURCES-1:0][PTR_W-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [NR_SOURCES-1:0][PTR_W-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [NR_SOURCES-1:0][CNT_W-1:0]                      count_q, count_d;
    logic [RR_W-1:0]                                       rr_q, rr_d;

    logic [NR_SOURCES-1:0]                 head_valid;
    logic [NR_SOURCES-1:0]                 head_bypass;
    logic [NR_SOURCES-1:0][4:0]            head_waddr;
    logic [NR_SOURCES-1:0][DATA_WIDTH-1:0] head_wdata;
    logic [NR_SOURCES-1:0]                 grant;
    logic [NR_SOURCES-1:0]                 push;
    logic [NR_SOURCES-1:0]                 pop_fifo;

    logic [RR_W:0]   scan_sum;
    logic [RR_W-1:0] scan_idx;
    logic            placed;
    logic            clash;

    // Ready and busy come straight from the registered counts.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < NR_SOURCES; i++) begin
            src_ready_o[i] = (count_q[i] != CNT_W'(FIFO_DEPTH));
            busy_o         = busy_o | (count_q[i] != '0);
        end
    end

    // Heads offered to the arbiter: FIFO front, or (bypass build) the live input.
    always_comb begin
        for (int i = 0; i < NR_SOURCES; i++) begin
            head_valid[i]  = (count_q[i] != '0);
            head_bypass[i] = 1'b0;
            head_waddr[i]  = mem_waddr_q[i][rd_ptr_q[i]];
            head_wdata[i]  = mem_wdata_q[i][rd_ptr_q[i]];
`ifdef WB_BYPASS_EN
            if ((count_q[i] == '0) && src_valid_i[i]) begin
                head_valid[i]  = 1'b1;
                head_bypass[i] = 1'b1;
                head_waddr[i]  = src_waddr_i[i];
                head_wdata[i]  = src_wdata_i[i];
            end
`endif
        end
    end

    // Round-robin scan. Ports fill in scan order, so a set we_o[k] always means
    // "already granted this cycle" and is what the duplicate-register check uses.
    always_comb begin
        grant    = '0;
        we_o     = '0;
        waddr_o  = '0;
        wdata_o  = '0;
        rr_d     = rr_q;
        scan_sum = '0;
        scan_idx = '0;
        placed   = 1'b0;
        clash    = 1'b0;
        for (int i = 0; i < NR_SOURCES; i++) begin
            scan_sum = {1'b0, rr_q} + (RR_W + 1)'(i);
            if (scan_sum >= (RR_W + 1)'(NR_SOURCES)) begin
                scan_sum = scan_sum - (RR_W + 1)'(NR_SOURCES);
            end
            scan_idx = scan_sum[RR_W-1:0];
            if (head_valid[scan_idx]) begin
                if (head_waddr[scan_idx] == 5'd0) begin
                    // x0 writes are discarded without using a port.
                    grant[scan_idx] = 1'b1;
                end else begin
                    clash  = 1'b0;
                    placed = 1'b0;
                    for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                        if (we_o[k] && (waddr_o[k] == head_waddr[scan_idx])) begin
                            clash = 1'b1;
                        end
                    end
                    for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                        if (!clash && !placed && !we_o[k]) begin
                            we_o[k]    = 1'b1;
                            waddr_o[k] = head_waddr[scan_idx];
                            wdata_o[k] = head_wdata[scan_idx];
                            placed     = 1'b1;
                        end
                    end
                    if (placed) begin
                        grant[scan_idx] = 1'b1;
                        rr_d = (scan_idx == RR_W'(NR_SOURCES - 1)) ? '0 : scan_idx + 1'b1;
                    end
                end
            end
        end
    end

    // FIFO bookkeeping. A granted bypass head is consumed directly and never stored.
    always_comb begin
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        for (int i = 0; i < NR_SOURCES; i++) begin
            push[i]     = src_valid_i[i] & src_ready_o[i] & ~(grant[i] & head_bypass[i]);
            pop_fifo[i] = grant[i] & ~head_bypass[i];
            if (push[i]) begin
                mem_waddr_d[i][wr_ptr_q[i]] = src_waddr_i[i];
                mem_wdata_d[i][wr_ptr_q[i]] = src_wdata_i[i];
                wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
            end
            if (pop_fifo[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
            end
            count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop_fifo[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rr_q        <= '0;
        end else begin
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            rr_q        <= rr_d;
        end
    end

`ifndef SYNTHESIS
    // A source must never get an entry into a full buffer.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int i = 0; i < NR_SOURCES; i++) begin
                assert (!(push[i] && (count_q[i] == CNT_W'(FIFO_DEPTH))))
                    else $error("push into full buffer on source %0d", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int NW = 2;
  localparam int FD = 2;

  logic                   clk;
  logic                   rst_n;
  logic [NS-1:0]          src_valid;
  logic [NS-1:0]          src_ready;
  logic [NS-1:0][4:0]     src_waddr;
  logic [NS-1:0][DW-1:0]  src_wdata;
  logic [NW-1:0][4:0]     waddr;
  logic [NW-1:0][DW-1:0]  wdata;
  logic [NW-1:0]          we;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(
    .DATA_WIDTH(DW), .NR_SOURCES(NS), .NR_WRITE_PORTS(NW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .src_valid_i(src_valid), .src_ready_o(src_ready),
    .src_waddr_i(src_waddr), .src_wdata_i(src_wdata),
    .waddr_o(waddr), .wdata_o(wdata), .we_o(we), .busy_o(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // reference model: one queue of pending results per source
  typedef struct packed {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[NS][$];
  int            m_rr;
  logic [NS-1:0] m_pop;
  logic [NS-1:0] m_push;
  int            m_last;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) mq[s].delete();
    m_rr   = 0;
    m_push = '0;
  endtask

  // Expected outputs for the present cycle, compared with the DUT.
  task automatic model_eval_check();
    logic [NW-1:0]         e_we;
    logic [NW-1:0][4:0]    e_a;
    logic [NW-1:0][DW-1:0] e_d;
    logic [NS-1:0]         e_rdy;
    logic                  e_busy;
    int                    s;
    int                    ng;
    bit                    dup;
    e_we = '0; e_a = '0; e_d = '0; m_pop = '0; m_last = -1; ng = 0; e_busy = 1'b0;
    for (int i = 0; i < NS; i++) begin
      s = (m_rr + i) % NS;
      if (mq[s].size() != 0) begin
        if (mq[s][0].a == 5'd0) begin
          m_pop[s] = 1'b1;
        end else if (ng < NW) begin
          dup = 1'b0;
          for (int k = 0; k < ng; k++) if (e_a[k] == mq[s][0].a) dup = 1'b1;
          if (!dup) begin
            e_we[ng] = 1'b1;
            e_a[ng]  = mq[s][0].a;
            e_d[ng]  = mq[s][0].d;
            ng++;
            m_pop[s] = 1'b1;
            m_last   = s;
          end
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      e_rdy[i]  = (mq[i].size() < FD);
      e_busy    = e_busy | (mq[i].size() != 0);
      m_push[i] = src_valid[i] & e_rdy[i];
    end
    chk("model_we", 64'(we), 64'(e_we));
    chk("model_ready", 64'(src_ready), 64'(e_rdy));
    chk("model_busy", 64'(busy), 64'(e_busy));
    for (int k = 0; k < NW; k++) begin
      if (e_we[k]) begin
        chk($sformatf("model_waddr%0d", k), 64'(waddr[k]), 64'(e_a[k]));
        chk($sformatf("model_wdata%0d", k), 64'(wdata[k]), 64'(e_d[k]));
      end
    end
  endtask

  // State the DUT should hold after the coming rising edge.
  task automatic model_commit();
    for (int s = 0; s < NS; s++) if (m_pop[s]) void'(mq[s].pop_front());
    for (int s = 0; s < NS; s++) if (m_push[s]) mq[s].push_back({src_waddr[s], src_wdata[s]});
    if (m_last >= 0) m_rr = (m_last + 1) % NS;
  endtask

  // random driver honouring the hold-until-accepted rule
  task automatic drive_random();
    for (int s = 0; s < NS; s++) begin
      if (!src_valid[s] || m_push[s]) begin
        src_valid[s] = ($urandom_range(0, 99) < 60);
        src_waddr[s] = 5'($urandom_range(0, 7));
        src_wdata[s] = $urandom();
      end
    end
  endtask

  task automatic run_random(input int n);
    for (int c = 0; c < n; c++) begin
      drive_random();
      @(negedge clk);
      model_eval_check();
      model_commit();
      @(posedge clk);
      #1;
    end
  endtask

  // directed vector table
  typedef struct {
    logic [NS-1:0]      valid;
    logic [NS-1:0][4:0] addr;
    logic [NW-1:0]      exp_we;
    logic [NW-1:0][4:0] exp_addr;
    logic               exp_busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic [3:0] v, input logic [4:0] a3, input logic [4:0] a2,
                         input logic [4:0] a1, input logic [4:0] a0, input logic [1:0] ewe,
                         input logic [4:0] p1, input logic [4:0] p0, input logic eb);
    vec_t r;
    r.valid    = v;
    r.addr     = {a3, a2, a1, a0};
    r.exp_we   = ewe;
    r.exp_addr = {p1, p0};
    r.exp_busy = eb;
    tbl.push_back(r);
  endtask

  initial begin
    bit filled;

    //        valid    a3  a2  a1  a0  we     p1  p0  busy
    add_row(4'b0101,   0,  9,  0,  5, 2'b00,  0,  0, 0); // src0 rd5, src2 rd9
    add_row(4'b0000,   0,  0,  0,  0, 2'b11,  9,  5, 1); // both written, rr->3
    add_row(4'b1000,   1,  0,  0,  0, 2'b00,  0,  0, 0); // steer rr back to 0
    add_row(4'b0000,   0,  0,  0,  0, 2'b01,  0,  1, 1);
    add_row(4'b1010,   7,  0,  7,  0, 2'b00,  0,  0, 0); // src1, src3 both rd7
    add_row(4'b0000,   0,  0,  0,  0, 2'b01,  0,  7, 1); // src1 only
    add_row(4'b0000,   0,  0,  0,  0, 2'b01,  0,  7, 1); // then src3
    add_row(4'b1111,  13, 12, 11, 10, 2'b00,  0,  0, 0); // four distinct rd
    add_row(4'b0000,   0,  0,  0,  0, 2'b11, 11, 10, 1); // {0,1}
    add_row(4'b0000,   0,  0,  0,  0, 2'b11, 13, 12, 1); // {2,3}
    add_row(4'b0001,   0,  0,  0,  0, 2'b00,  0,  0, 0); // src0 rd0
    add_row(4'b0001,   0,  0,  0,  4, 2'b00,  0,  0, 1); // rd0 dropped, rd4 pushed
    add_row(4'b0000,   0,  0,  0,  0, 2'b01,  0,  4, 1); // rd4 written, rr->1
    add_row(4'b0111,   0, 21, 20,  0, 2'b00,  0,  0, 0); // rd0 alongside two writes
    add_row(4'b0000,   0,  0,  0,  0, 2'b11, 21, 20, 1); // rd0 uses no port
    add_row(4'b0000,   0,  0,  0,  0, 2'b00,  0,  0, 0);

    // reset with all sources asserting valid
    src_valid = '1;
    for (int s = 0; s < NS; s++) begin
      src_waddr[s] = 5'(s + 3);
      src_wdata[s] = $urandom();
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(src_ready), 64'hF);
    chk("rst_we", 64'(we), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ready_held", 64'(src_ready), 64'hF);
    chk("rst_busy_held", 64'(busy), 64'h0);
    src_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // table-driven directed sequence
    for (int r = 0; r < tbl.size(); r++) begin
      src_valid = tbl[r].valid;
      src_waddr = tbl[r].addr;
      for (int s = 0; s < NS; s++) src_wdata[s] = 32'hD000_0000 | (r << 8) | s;
      @(negedge clk);
      chk($sformatf("row%0d_we", r), 64'(we), 64'(tbl[r].exp_we));
      chk($sformatf("row%0d_busy", r), 64'(busy), 64'(tbl[r].exp_busy));
      chk($sformatf("row%0d_ready", r), 64'(src_ready), 64'hF);
      for (int k = 0; k < NW; k++) begin
        if (tbl[r].exp_we[k]) begin
          chk($sformatf("row%0d_waddr%0d", r, k), 64'(waddr[k]), 64'(tbl[r].exp_addr[k]));
        end
      end
      model_eval_check();
      model_commit();
      @(posedge clk);
      #1;
    end

    // randomized traffic against the model
    src_valid = '0;
    m_push    = '0;
    run_random(300);

    // saturate every source until source 1 is full, then reset mid-stream
    for (int s = 0; s < NS; s++) begin
      if (!src_valid[s] || m_push[s]) begin
        src_valid[s] = 1'b1;
        src_waddr[s] = 5'(s + 1);
        src_wdata[s] = $urandom();
      end
    end
    filled = 1'b0;
    for (int c = 0; c < 20 && !filled; c++) begin
      @(negedge clk);
      model_eval_check();
      if (mq[1].size() == FD) begin
        chk("full_ready1", 64'(src_ready[1]), 64'h0);
        filled = 1'b1;
      end else begin
        model_commit();
        @(posedge clk);
        #1;
        for (int s = 0; s < NS; s++) begin
          if (m_push[s]) begin
            src_valid[s] = 1'b1;
            src_waddr[s] = 5'(s + 1);
            src_wdata[s] = $urandom();
          end
        end
      end
    end
    if (!filled) begin
      checks++;
      errors++;
      $display("FAIL fill_timeout actual=not_full expected=full");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", 64'(we), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_ready", 64'(src_ready), 64'hF);
    model_reset();
    src_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // traffic after the mid-stream reset
    run_random(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Writeback stage directly upstream of the FPGA register file. It collects results from NR_SOURCES functional-unit channels (valid/ready), buffers them per source, and each cycle drives up to NR_WRITE_PORTS register-file write ports. Grants rotate round-robin, and the block guarantees that no two write ports target the same register in the same cycle. The register file therefore never relies on its write-port priority rule.

Parameters:
DATA_WIDTH, 32, result/register width
NR_SOURCES, 4, number of functional-unit result channels
NR_WRITE_PORTS, 2, register-file write ports driven (1..NR_SOURCES)
FIFO_DEPTH, 2, entries per source buffer (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
src_valid_i  in  NR_SOURCES  result valid per source
src_ready_o  out  NR_SOURCES  source buffer can accept
src_waddr_i  in  NR_SOURCES x 5  destination register per source
src_wdata_i  in  NR_SOURCES x DATA_WIDTH  result data per source
waddr_o  out  NR_WRITE_PORTS x 5  register-file write address
wdata_o  out  NR_WRITE_PORTS x DATA_WIDTH  register-file write data
we_o  out  NR_WRITE_PORTS  register-file write enable
busy_o  out  1  any source buffer non-empty

Behaviour:
- Clock/reset: clk_i and rst_ni, asynchronous active-low reset. Reset clears all FIFOs (counts 0) and sets the round-robin pointer rr_q to 0.
- Reset values: src_ready_o all 1 (src_ready_o = count<FIFO_DEPTH, registered state only), we_o 0, busy_o 0. waddr_o/wdata_o are don't-care while we_o=0; drive 0.
- Handshake: a push happens on src_valid_i & src_ready_o. The source holds valid and payload until the push. src_ready_o never depends combinationally on src_valid_i.
- Per-source FIFO: order is preserved within a source. A push and a pop in the same cycle is allowed when full, but ready still reflects the registered count. Pointers wrap modulo FIFO_DEPTH.
- Arbitration (combinational on FIFO heads, registered state only):
  - Scan sources starting at rr_q, wrapping.
  - A head with waddr=0 is popped and consumes no write port. It is never forwarded (we_o stays 0 for it).
  - A non-zero head is granted if a free port remains and its waddr differs from every head already granted this cycle. Otherwise it waits.
  - The k-th grant in scan order drives port k. Unused ports have we_o=0.
  - Granted heads are popped this cycle.
- Pointer update: if at least one non-zero grant occurs, rr_q <= (index of last granted source + 1) mod NR_SOURCES. Otherwise rr_q holds.
- Latency: a result pushed in cycle T appears on we_o no earlier than T+1. Outputs are combinational from FIFO heads.
- Fairness: any non-empty source is granted within NR_SOURCES cycles.
- Ordering: same-register ordering across different sources is not guaranteed. The upstream scoreboard forbids outstanding WAW across units.
- Full: no push while count=FIFO_DEPTH. A push arriving while full is a source protocol violation; assert it in simulation.
- Reset mid-operation: pending entries are discarded and we_o drops asynchronously.
- busy_o = OR of (count!=0).

Optional Feature:
Macro WB_BYPASS_EN.
- Defined: when a source FIFO is empty and src_valid_i is high, that input participates in arbitration in the same cycle as a virtual head. If it is granted, it drives we_o in cycle T (zero latency) and is not written into the FIFO. src_ready_o is unchanged, so there is still no combinational valid-to-ready path.
- Undefined: minimum latency is 1 cycle as stated above.

Test Plan:
1. Reset with all src_valid_i=1 -> during reset src_ready_o=4'b1111, we_o=0, busy_o=0. After release, first pushes appear on we_o the next cycle (bypass off).
2. Sources 0 and 2 push rd=5 and rd=9 in cycle T, rr_q=0 -> at T+1 port0={5,d0}, port1={9,d2}, we_o=2'b11, rr_q becomes 3.
3. Sources 1 and 3 both push rd=7, rr_q=0 -> T+1: only src1 is written on port0, we_o=2'b01. T+2: src3 is written on port0 with rd=7.
4. Sources 0,1,2,3 each push distinct rd -> two writes per cycle. Grant order is {0,1} then {2,3}, rr_q sequence 0->2->0.
5. Source 0 pushes rd=0 then rd=4 -> the rd=0 entry is popped with we_o=0. rd=4 is written one cycle later. No port is consumed by rd=0.
6. Fill source 1 to FIFO_DEPTH while its grants are blocked, then assert rst_ni=0 mid-stream -> src_ready_o[1]=0 when full. On reset, we_o=0 immediately, all FIFOs are empty, and busy_o=0.
